ascon_round_fsm: RTL and testbench

- Moore/Mealy control FSM for the ASCON-128 datapath. Sequences initialisation, one associated-data block, N plaintext blocks and finalisation.
- Sits directly upstream of the round counter: drives its en_round/init_a/init_b inputs and reads back the 4-bit round index.
- Also drives the permutation/state-register control strobes and the host-side valid flags.

---
 rtl/ascon_round_fsm.sv | 164 ++++++++++++++++
 tb/tb_ascon_round_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_round_fsm.sv
// ASCON-128 control FSM: sequences init, one AD block, N plaintext blocks and finalisation,
// driving the round counter strobes and the state-register/XOR controls.
module ascon_round_fsm #(
    parameter logic [3:0]  LAST_RND = 4'd11,
    parameter logic [3:0]  PB_FIRST = 4'd6,
    parameter int unsigned BLK_W    = 8
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             data_valid_i,
    input  logic             last_block_i,
    input  logic [3:0]       cpt_i,
    output logic             en_round_o,
    output logic             init_a_o,
    output logic             init_b_o,
    output logic             load_state_o,
    output logic             en_state_o,
    output logic             xor_data_begin_o,
    output logic             xor_key_begin_o,
    output logic             xor_key_end_o,
    output logic             xor_lsb_end_o,
    output logic             cipher_valid_o,
    output logic             tag_valid_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [BLK_W-1:0] blk_cnt_o
);

    typedef enum logic [3:0] {
        StIdle,
        StConfInit,
        StInitRnd,
        StWaitAd,
        StAdRnd,
        StWaitPt,
        StPtRnd,
        StFinRnd,
        StTag
    } state_e;

    state_e           state_q, state_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q   <= StIdle;
            blk_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            blk_cnt_q <= blk_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        blk_cnt_d        = blk_cnt_q;
        en_round_o       = 1'b0;
        init_a_o         = 1'b0;
        init_b_o         = 1'b0;
        load_state_o     = 1'b0;
        en_state_o       = 1'b0;
        xor_data_begin_o = 1'b0;
        xor_key_begin_o  = 1'b0;
        xor_key_end_o    = 1'b0;
        xor_lsb_end_o    = 1'b0;
        cipher_valid_o   = 1'b0;
        tag_valid_o      = 1'b0;
        done_o           = 1'b0;
        busy_o           = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StConfInit;
                    blk_cnt_d = '0;
                end
            end
            StConfInit: begin
                en_round_o   = 1'b1;
                init_a_o     = 1'b1;
                load_state_o = 1'b1;
                state_d      = StInitRnd;
            end
            StInitRnd: begin
                en_round_o = 1'b1;
                en_state_o = 1'b1;
                if (cpt_i >= LAST_RND) begin
                    xor_key_end_o = 1'b1;
                    state_d       = StWaitAd;
                end
            end
            StWaitAd: begin
                if (data_valid_i) begin
                    en_round_o = 1'b1;
                    init_b_o   = 1'b1;
                    state_d    = StAdRnd;
                end
            end
            StAdRnd: begin
                en_round_o = 1'b1;
                en_state_o = 1'b1;
                if (cpt_i == PB_FIRST) begin
                    xor_data_begin_o = 1'b1;
                end
                if (cpt_i >= LAST_RND) begin
                    xor_lsb_end_o = 1'b1;
                    state_d       = StWaitPt;
                end
            end
            StWaitPt: begin
                if (data_valid_i) begin
                    en_round_o = 1'b1;
                    if (blk_cnt_q != '1) begin
                        blk_cnt_d = blk_cnt_q + BLK_W'(1);
                    end
                    // Last block goes straight into the 12-round finalisation.
                    if (last_block_i) begin
                        init_a_o = 1'b1;
                        state_d  = StFinRnd;
                    end else begin
                        init_b_o = 1'b1;
                        state_d  = StPtRnd;
                    end
                end
            end
            StPtRnd: begin
                en_round_o = 1'b1;
                en_state_o = 1'b1;
                if (cpt_i == PB_FIRST) begin
                    xor_data_begin_o = 1'b1;
                    cipher_valid_o   = 1'b1;
                end
                if (cpt_i >= LAST_RND) begin
                    state_d = StWaitPt;
                end
            end
            StFinRnd: begin
                en_round_o = 1'b1;
                en_state_o = 1'b1;
                if (cpt_i == 4'd0) begin
                    xor_data_begin_o = 1'b1;
                    xor_key_begin_o  = 1'b1;
                    cipher_valid_o   = 1'b1;
                end
                if (cpt_i >= LAST_RND) begin
                    xor_key_end_o = 1'b1;
                    state_d       = StTag;
                end
            end
            StTag: begin
                tag_valid_o = 1'b1;
                done_o      = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign blk_cnt_o = blk_cnt_q;

endmodule

// File: tb/tb_ascon_round_fsm.sv
// Scoreboard bench for ascon_round_fsm: per-cycle expected control vectors are queued as
// stimulus is driven and compared at the falling edge; two DUTs cover BLK_W=8 and BLK_W=2.
module tb_ascon_round_fsm;

    localparam logic [3:0] PB_FIRST = 4'd6;

    localparam logic [12:0] O_ER   = 13'h1000;
    localparam logic [12:0] O_IA   = 13'h0800;
    localparam logic [12:0] O_IB   = 13'h0400;
    localparam logic [12:0] O_LS   = 13'h0200;
    localparam logic [12:0] O_ES   = 13'h0100;
    localparam logic [12:0] O_XDB  = 13'h0080;
    localparam logic [12:0] O_XKB  = 13'h0040;
    localparam logic [12:0] O_XKE  = 13'h0020;
    localparam logic [12:0] O_XLE  = 13'h0010;
    localparam logic [12:0] O_CV   = 13'h0008;
    localparam logic [12:0] O_TV   = 13'h0004;
    localparam logic [12:0] O_DONE = 13'h0002;
    localparam logic [12:0] O_BUSY = 13'h0001;

    typedef struct {
        logic        st;
        logic        dv;
        logic        lb;
        logic [12:0] exp;
        int          blk;
        logic        chk;
        logic [3:0]  cpt;
    } step_t;

    logic clock, resetb, start, data_valid, last_block;
    logic [3:0] cpt1, cpt2;
    logic er1, ia1, ib1, ls1, es1, xdb1, xkb1, xke1, xle1, cv1, tv1, dn1, bz1;
    logic er2, ia2, ib2, ls2, es2, xdb2, xkb2, xke2, xle2, cv2, tv2, dn2, bz2;
    logic [7:0] blk1;
    logic [1:0] blk2;
    logic [12:0] outs1, outs2;

    int n_checks = 0;
    int n_fail   = 0;
    int blk_hold = 0;
    step_t sb_q[$];

    assign outs1 = {er1, ia1, ib1, ls1, es1, xdb1, xkb1, xke1, xle1, cv1, tv1, dn1, bz1};
    assign outs2 = {er2, ia2, ib2, ls2, es2, xdb2, xkb2, xke2, xle2, cv2, tv2, dn2, bz2};

    ascon_round_fsm dut1 (
        .clock_i(clock), .resetb_i(resetb), .start_i(start), .data_valid_i(data_valid),
        .last_block_i(last_block), .cpt_i(cpt1), .en_round_o(er1), .init_a_o(ia1),
        .init_b_o(ib1), .load_state_o(ls1), .en_state_o(es1), .xor_data_begin_o(xdb1),
        .xor_key_begin_o(xkb1), .xor_key_end_o(xke1), .xor_lsb_end_o(xle1),
        .cipher_valid_o(cv1), .tag_valid_o(tv1), .done_o(dn1), .busy_o(bz1), .blk_cnt_o(blk1)
    );

    ascon_round_fsm #(.BLK_W(2)) dut2 (
        .clock_i(clock), .resetb_i(resetb), .start_i(start), .data_valid_i(data_valid),
        .last_block_i(last_block), .cpt_i(cpt2), .en_round_o(er2), .init_a_o(ia2),
        .init_b_o(ib2), .load_state_o(ls2), .en_state_o(es2), .xor_data_begin_o(xdb2),
        .xor_key_begin_o(xkb2), .xor_key_end_o(xke2), .xor_lsb_end_o(xle2),
        .cipher_valid_o(cv2), .tag_valid_o(tv2), .done_o(dn2), .busy_o(bz2), .blk_cnt_o(blk2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Round counter models, one per DUT.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cpt1 <= 4'd0;
        end else if (er1) begin
            cpt1 <= ia1 ? 4'd0 : (ib1 ? PB_FIRST : cpt1 + 4'd1);
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            cpt2 <= 4'd0;
        end else if (er2) begin
            cpt2 <= ia2 ? 4'd0 : (ib2 ? PB_FIRST : cpt2 + 4'd1);
        end
    end

    function automatic step_t mk(input logic st, input logic dv, input logic lb,
                                 input logic [12:0] e, input int blk, input logic chk,
                                 input logic [3:0] c);
        step_t s;
        s.st = st; s.dv = dv; s.lb = lb; s.exp = e; s.blk = blk; s.chk = chk; s.cpt = c;
        return s;
    endfunction

    task automatic test_reset();
        bit reached;
        resetb = 1'b0; start = 1'b0; data_valid = 1'b0; last_block = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (outs1 !== 13'h0 || outs2 !== 13'h0 || blk1 !== 8'd0 || blk2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state outs=%h/%h blk=%0d/%0d required 0", outs1, outs2,
                     blk1, blk2);
        end
        @(posedge clock); #1;
        resetb = 1'b1;
        start  = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            @(negedge clock);
            if (es1 === 1'b1 && cpt1 == 4'd5) reached = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("FAIL reset_reach_cpt5 reached=0 required 1");
        end
        #2;
        resetb = 1'b0;
        #1;
        n_checks++;
        if (outs1 !== 13'h0 || bz1 !== 1'b0 || blk1 !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_async outs=%h busy=%b blk=%0d required 0", outs1, bz1, blk1);
        end
        @(posedge clock); #1;
        resetb   = 1'b1;
        blk_hold = 0;
    endtask

    // Full encryption flow: plan built up front, expected vectors queued as each step is
    // driven, compared at the falling edge.
    task automatic test_encrypt(input string name, input int ad_wait, input int nblk,
                                input bit inject, input bit dv_with_start);
        step_t plan[$];
        step_t e;
        int blk;
        int sat;
        logic last;
        blk = blk_hold;
        plan.push_back(mk(1, dv_with_start, 0, 13'h0, blk, 0, 0));
        blk = 0;
        plan.push_back(mk(0, 0, 0, O_ER | O_IA | O_LS | O_BUSY, blk, 0, 0));
        for (int k = 0; k < 12; k++)
            plan.push_back(mk(0, 0, 0, O_ER | O_ES | O_BUSY | ((k == 11) ? O_XKE : 13'h0),
                              blk, 1, 4'(k)));
        for (int w = 0; w < ad_wait; w++)
            plan.push_back(mk(0, 0, 0, O_BUSY, blk, 0, 0));
        plan.push_back(mk(0, 1, 0, O_ER | O_IB | O_BUSY, blk, 0, 0));
        for (int k = 6; k < 12; k++)
            plan.push_back(mk(0, 0, 0, O_ER | O_ES | O_BUSY | ((k == 6) ? O_XDB : 13'h0) |
                              ((k == 11) ? O_XLE : 13'h0), blk, 1, 4'(k)));
        for (int b = 1; b <= nblk; b++) begin
            last = (b == nblk);
            if (b == 2)
                plan.push_back(mk(0, 0, 0, O_BUSY, blk, 0, 0));
            plan.push_back(mk(0, 1, last, O_ER | (last ? O_IA : O_IB) | O_BUSY, blk, 0, 0));
            blk++;
            if (!last) begin
                for (int k = 6; k < 12; k++)
                    plan.push_back(mk(inject && b == 1 && k == 8, inject && b == 1 && k == 8,
                                      inject && b == 1 && k == 8,
                                      O_ER | O_ES | O_BUSY | ((k == 6) ? (O_XDB | O_CV) : 13'h0),
                                      blk, 1, 4'(k)));
            end else begin
                for (int k = 0; k < 12; k++)
                    plan.push_back(mk(0, 0, 0, O_ER | O_ES | O_BUSY |
                                      ((k == 0) ? (O_XDB | O_XKB | O_CV) : 13'h0) |
                                      ((k == 11) ? O_XKE : 13'h0), blk, 1, 4'(k)));
            end
        end
        plan.push_back(mk(0, 0, 0, O_TV | O_DONE | O_BUSY, blk, 0, 0));
        plan.push_back(mk(0, 1, 0, 13'h0, blk, 0, 0));

        for (int i = 0; i < plan.size(); i++) begin
            start      = plan[i].st;
            data_valid = plan[i].dv;
            last_block = plan[i].lb;
            sb_q.push_back(plan[i]);
            @(negedge clock);
            e   = sb_q.pop_front();
            sat = (e.blk > 3) ? 3 : e.blk;
            n_checks++;
            if (outs1 !== e.exp || outs2 !== e.exp || blk1 !== 8'(e.blk) ||
                blk2 !== 2'(sat) || (e.chk && cpt1 !== e.cpt)) begin
                n_fail++;
                $display("FAIL %s cyc=%0d outs=%h/%h blk=%0d/%0d cpt=%0d required outs=%h blk=%0d/%0d cpt=%0d",
                         name, i, outs1, outs2, blk1, blk2, cpt1, e.exp, e.blk, sat, e.cpt);
            end
            @(posedge clock); #1;
        end
        start = 1'b0; data_valid = 1'b0; last_block = 1'b0;
        blk_hold = blk;
    endtask

    task automatic test_full();
        test_encrypt("full", 3, 3, 0, 0);
    endtask

    task automatic test_ignore();
        test_encrypt("ignore", 0, 3, 1, 1);
    endtask

    task automatic test_saturation();
        test_encrypt("saturation", 1, 5, 0, 0);
    endtask

    task automatic test_back_to_back();
        test_encrypt("back_to_back", 0, 1, 0, 1);
    endtask

    initial begin
        test_reset();
        test_full();
        test_ignore();
        test_saturation();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
